mio_bus_arbiter: RTL and testbench

- Shares the single MIO data bus (Address/Data_out/Data_in/write/MIO_ready) between two requesters: master 0 = CPU MEM stage, master 1 = auxiliary engine (DMA/debug loader).
- Runs one transaction at a time, absorbs MIO_ready wait states, and raises a per-master stall so the pipeline freezes until its access completes.
- Sits between the pipeline top level and the MIO bus; a timeout aborts hung accesses.

---
 rtl/mio_bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mio_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_arbiter.sv
// rtl/mio_bus_arbiter.sv - two-master arbiter for the shared MIO data bus
//
// Purpose:
//   Serialises accesses from master 0 (CPU MEM stage) and master 1 (auxiliary
//   DMA/debug engine) onto the single MIO bus. One transaction at a time,
//   MIO_ready wait states absorbed, per-master stall while an access is
//   outstanding, and a timeout that aborts hung accesses with ERR_DATA.
//
// Optional feature macro:
//   ARB_ROUND_ROBIN_EN - when defined, ties in IDLE go to the master not served
//                        last; otherwise master 0 always wins a tie.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   mX_req/we/addr/wdata      master X request, held until mX_done
//   mX_rdata                  master X read data, valid while mX_done
//   mX_done                   one-cycle completion pulse to master X
//   mX_stall                  mX_req & ~mX_done
//   bus_req/we/addr/wdata     MIO bus request side, driven from latched values
//   bus_rdata, bus_ready      MIO bus read data and ready
//   timeout_err               pulses together with the done of an aborted access

module mio_bus_arbiter #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_stall,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic        m1_stall,

    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,

    output logic        timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;   // 0 = master 0, 1 = master 1
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      rdata0_q, rdata0_d;
    logic [31:0]      rdata1_q, rdata1_d;
    logic             grant1;

`ifdef ARB_ROUND_ROBIN_EN
    // Last served master; resets to 1 so master 0 wins the first tie.
    logic             last_q, last_d;

    always_comb begin
        grant1 = m1_req & (~m0_req | ~last_q);
    end
`else
    always_comb begin
        grant1 = m1_req & ~m0_req;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= last_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d   = last_q;
`endif

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    owner_d = grant1;
                    we_d    = grant1 ? m1_we    : m0_we;
                    addr_d  = grant1 ? m1_addr  : m0_addr;
                    wdata_d = grant1 ? m1_wdata : m0_wdata;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = grant1;
`endif
                end
            end

            ACCESS: begin
                // Ready wins over timeout on the same edge.
                if (bus_ready) begin
                    if (owner_q) rdata1_d = bus_rdata;
                    else         rdata0_d = bus_rdata;
                    state_d = DONE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    if (owner_q) rdata1_d = ERR_DATA;
                    else         rdata0_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus_req     = (state_q == ACCESS);
    assign bus_we      = bus_req & we_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;

    assign m0_done     = (state_q == DONE) & ~owner_q;
    assign m1_done     = (state_q == DONE) &  owner_q;
    assign m0_rdata    = rdata0_q;
    assign m1_rdata    = rdata1_q;
    assign m0_stall    = m0_req & ~m0_done;
    assign m1_stall    = m1_req & ~m1_done;
    assign timeout_err = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb/tb_mio_bus_arbiter.sv - scoreboard testbench for mio_bus_arbiter

module tb_mio_bus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_done, m0_stall;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_done, m1_stall;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        bus_req, bus_we, bus_ready, timeout_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    // Bus model: ready rises after wait_n ACCESS cycles of the current access.
    int wait_n     = 0;
    int acc_cycles = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!bus_req) acc_cycles <= 0;
        else          acc_cycles <= acc_cycles + 1;
    end

    assign bus_ready = (acc_cycles >= wait_n);

    mio_bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_stall(m0_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_stall(m1_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready), .timeout_err(timeout_err)
    );

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected completion.
    always @(negedge clk) begin : monitor
        exp_t        e;
        int          m;
        logic [31:0] rd;
        if (rst === 1'b1 && (m0_done || m1_done)) begin
            m  = m1_done ? 1 : 0;
            rd = m1_done ? m1_rdata : m0_rdata;
            chk("single_done", 32'(m0_done & m1_done), 32'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: m%0d done with empty scoreboard", m);
            end else begin
                e = sb.pop_front();
                chk("done_master", 32'(m), 32'(e.m));
                chk("done_rdata", rd, e.rdata);
                chk("done_timeout_err", 32'(timeout_err), 32'(e.err));
            end
        end
    end

    task automatic drive(input int m, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
        end
    endtask

    // Waits for master m's done; counts ACCESS and stall cycles and flags any
    // bus value that differs from the expected latched request.
    task automatic wait_done(input int m, input logic [31:0] ea, input logic [31:0] ed,
                             input logic ewe, output int acc_n, output int stall_n,
                             output logic bad);
        logic got;
        acc_n = 0; stall_n = 0; bad = 1'b0; got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus_req) begin
                acc_n++;
                if (bus_addr !== ea || bus_wdata !== ed || bus_we !== ewe) bad = 1'b1;
            end
            if ((m == 0) ? m0_stall : m1_stall) stall_n++;
            if ((m == 0) ? m0_done : m1_done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_done_m%0d: no done within 60 cycles", m);
        end
        @(posedge clk);
        #1;
    endtask

    int   acc, stl, ndone;
    logic bad;

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 32'd0, 32'd0);
        drive(1, 0, 0, 32'd0, 32'd0);
        bus_rdata = 32'd0;
        wait_n    = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {25'd0, bus_req, bus_we, m0_done, m1_done, timeout_err, m0_stall, m1_stall}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Zero-wait read on master 0.
        bus_rdata = 32'h1234_5678;
        wait_n    = 0;
        sb.push_back('{0, 32'h1234_5678, 1'b0});
        drive(0, 1, 0, 32'h0000_0010, 32'h0);
        wait_done(0, 32'h0000_0010, 32'h0, 1'b0, acc, stl, bad);
        drive(0, 0, 0, 32'h0, 32'h0);
        chk("zw_access_cycles", 32'(acc), 32'd1);
        chk("zw_stall_cycles", 32'(stl), 32'd2);
        chk("zw_bus_stable", 32'(bad), 32'd0);
        chk("zw_m1_rdata_untouched", m1_rdata, 32'd0);

        // Wait-state write on master 1.
        bus_rdata = 32'h0BAD_0BAD;
        wait_n    = 4;
        sb.push_back('{1, 32'h0BAD_0BAD, 1'b0});
        drive(1, 1, 1, 32'h8000_0000, 32'hA5A5_A5A5);
        wait_done(1, 32'h8000_0000, 32'hA5A5_A5A5, 1'b1, acc, stl, bad);
        drive(1, 0, 0, 32'h0, 32'h0);
        chk("ws_access_cycles", 32'(acc), 32'd5);
        chk("ws_stall_cycles", 32'(stl), 32'd6);
        chk("ws_bus_stable", 32'(bad), 32'd0);
        chk("ws_m0_rdata_untouched", m0_rdata, 32'h1234_5678);

        // Contention.
        bus_rdata = 32'h1111_0000;
        wait_n    = 1;
`ifdef ARB_ROUND_ROBIN_EN
        sb.push_back('{0, 32'h1111_0000, 1'b0});
        sb.push_back('{1, 32'h1111_0000, 1'b0});
        sb.push_back('{0, 32'h1111_0000, 1'b0});
        sb.push_back('{1, 32'h1111_0000, 1'b0});
        drive(0, 1, 0, 32'h0000_0100, 32'h0);
        drive(1, 1, 0, 32'h0000_0200, 32'h0);
        ndone = 0;
        for (int k = 0; k < 80 && ndone < 4; k++) begin
            @(negedge clk);
            if (m0_done || m1_done) ndone++;
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 32'h0, 32'h0);
        drive(1, 0, 0, 32'h0, 32'h0);
        chk("rr_done_count", 32'(ndone), 32'd4);
`else
        sb.push_back('{0, 32'h1111_0000, 1'b0});
        sb.push_back('{1, 32'h1111_0000, 1'b0});
        drive(0, 1, 0, 32'h0000_0100, 32'h0);
        drive(1, 1, 0, 32'h0000_0200, 32'h0);
        wait_done(0, 32'h0000_0100, 32'h0, 1'b0, acc, stl, bad);
        drive(0, 0, 0, 32'h0, 32'h0);
        chk("fp_loser_stall", 32'(m1_stall), 32'd1);
        wait_done(1, 32'h0000_0200, 32'h0, 1'b0, acc, stl, bad);
        drive(1, 0, 0, 32'h0, 32'h0);

        // Master 0 re-requests immediately: master 1 starves.
        sb.push_back('{0, 32'h1111_0000, 1'b0});
        sb.push_back('{0, 32'h1111_0000, 1'b0});
        sb.push_back('{1, 32'h1111_0000, 1'b0});
        drive(0, 1, 0, 32'h0000_0100, 32'h0);
        drive(1, 1, 0, 32'h0000_0200, 32'h0);
        wait_done(0, 32'h0000_0100, 32'h0, 1'b0, acc, stl, bad);
        chk("fp_starve_stall1", 32'(m1_stall), 32'd1);
        wait_done(0, 32'h0000_0100, 32'h0, 1'b0, acc, stl, bad);
        drive(0, 0, 0, 32'h0, 32'h0);
        chk("fp_starve_stall2", 32'(m1_stall), 32'd1);
        wait_done(1, 32'h0000_0200, 32'h0, 1'b0, acc, stl, bad);
        drive(1, 0, 0, 32'h0, 32'h0);
`endif

        // Timeout: ready stuck low.
        wait_n = 100;
        sb.push_back('{0, 32'hFFFF_FFFF, 1'b1});
        drive(0, 1, 0, 32'h0000_0040, 32'h0);
        wait_done(0, 32'h0000_0040, 32'h0, 1'b0, acc, stl, bad);
        drive(0, 0, 0, 32'h0, 32'h0);
        chk("to_access_cycles", 32'(acc), 32'(TO + 1));

        // Ready arrives on the edge that would have timed out.
        wait_n    = TO;
        bus_rdata = 32'hCAFE_0001;
        sb.push_back('{0, 32'hCAFE_0001, 1'b0});
        drive(0, 1, 0, 32'h0000_0044, 32'h0);
        wait_done(0, 32'h0000_0044, 32'h0, 1'b0, acc, stl, bad);
        drive(0, 0, 0, 32'h0, 32'h0);
        chk("to_edge_access_cycles", 32'(acc), 32'(TO + 1));

        // Asynchronous reset in the middle of an access: no done expected.
        wait_n = 100;
        drive(1, 1, 1, 32'h0000_0200, 32'h0000_0055);
        repeat (3) @(negedge clk);
        chk("ar_bus_req_before", 32'(bus_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_bus_req_drop", 32'(bus_req), 32'd0);
        chk("ar_bus_we_drop", 32'(bus_we), 32'd0);
        drive(1, 0, 0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ar_idle_bus_req", 32'(bus_req), 32'd0);
        end
        chk("ar_m0_rdata_cleared", m0_rdata, 32'd0);
        @(posedge clk); #1;

        // Normal access after reset release.
        wait_n    = 0;
        bus_rdata = 32'h600D_F00D;
        sb.push_back('{1, 32'h600D_F00D, 1'b0});
        drive(1, 1, 0, 32'h0000_0300, 32'h0);
        wait_done(1, 32'h0000_0300, 32'h0, 1'b0, acc, stl, bad);
        drive(1, 0, 0, 32'h0, 32'h0);
        chk("post_rst_access_cycles", 32'(acc), 32'd1);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
